// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi channel-model blocks: symbol type,
// channel-injector state encoding, LFSR polynomial and default seed.
package viterbi_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        HOLDOFF = 2'd1,
        BURST   = 2'd2
    } ch_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over state[15:0].
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Single-bit flip mask chosen by one LFSR bit; always one-hot.
    function automatic sym_t flip_mask(input logic sel_hi);
        return sel_hi ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/viterbi_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when step is high. A zero seed
// would lock the register, so it is replaced by the default seed.
module viterbi_lfsr16
    import viterbi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    assign state    = state_q;

    // Advance by one step per request, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    // LFSR register, reloaded with the seed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= seed_eff;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/viterbi_channel_err_inj.sv
// Channel error injector between the convolutional encoder and the Viterbi
// decoder. Flips single bits of accepted symbols pseudo-randomly, keeps a
// minimum clean gap after each fault and counts flipped bits (saturating).
// Optional burst mode is enabled by defining VITERBI_CH_ERR_BURST_EN.
module viterbi_channel_err_inj
    import viterbi_pkg::*;
#(
    parameter int          MIN_GAP   = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          CNT_W     = 16,
    parameter int          BURST_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_valid_i,
    input  logic [1:0]       enc_i,
    input  logic             err_en_i,
    input  logic [7:0]       err_rate_i,
    input  logic             clr_cnt_i,
    output logic [1:0]       ch_o,
    output logic             ch_valid_o,
    output logic [1:0]       err_inj_o,
    output logic [CNT_W-1:0] bad_bit_ct_o
);

    localparam int               GAP_W    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Pre-step LFSR value; every decision for the current symbol uses it.
    logic [15:0] lfsr_l;

    viterbi_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (enc_valid_i),
        .seed  (SEED),
        .state (lfsr_l)
    );

    ch_state_t        state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    sym_t             ch_q, ch_d;
    logic             ch_valid_q, ch_valid_d;
    sym_t             err_inj_q, err_inj_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sym_t             mask;
    logic             hit;

    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_l[15:9];

`ifdef VITERBI_CH_ERR_BURST_EN
    localparam int                 BURST_W    = $clog2(BURST_LEN + 1);
    localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURST_LEN - 1);
    logic [BURST_W-1:0] burst_q, burst_d;
`else
    logic [31:0] unused_burst_len;
    assign unused_burst_len = 32'(BURST_LEN);
`endif

    assign hit = err_en_i && (lfsr_l[7:0] < err_rate_i);

    // Next-state and flip-mask decision; advances only on accepted symbols.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        mask    = '0;
`ifdef VITERBI_CH_ERR_BURST_EN
        burst_d = burst_q;
`endif
        if (enc_valid_i) begin
            if (!err_en_i) begin
                // Disabling injection drops any holdoff or burst in progress.
                state_d = ARMED;
                gap_d   = '0;
`ifdef VITERBI_CH_ERR_BURST_EN
                burst_d = '0;
`endif
            end else begin
                case (state_q)
                    ARMED: begin
                        if (hit) begin
                            mask = flip_mask(lfsr_l[8]);
`ifdef VITERBI_CH_ERR_BURST_EN
                            if ((lfsr_l[15:12] == 4'hF) && (BURST_LEN > 1)) begin
                                state_d = BURST;
                                burst_d = BURST_LOAD;
                            end else
`endif
                            if (MIN_GAP > 0) begin
                                state_d = HOLDOFF;
                                gap_d   = GAP_LOAD;
                            end
                        end
                    end
                    HOLDOFF: begin
                        // Last clean symbol of the gap re-arms for the next one.
                        if (gap_q <= GAP_W'(1)) begin
                            state_d = ARMED;
                            gap_d   = '0;
                        end else begin
                            gap_d = gap_q - GAP_W'(1);
                        end
                    end
`ifdef VITERBI_CH_ERR_BURST_EN
                    BURST: begin
                        // Every burst symbol is flipped regardless of rate.
                        mask = flip_mask(lfsr_l[8]);
                        if (burst_q <= BURST_W'(1)) begin
                            burst_d = '0;
                            if (MIN_GAP > 0) begin
                                state_d = HOLDOFF;
                                gap_d   = GAP_LOAD;
                            end else begin
                                state_d = ARMED;
                            end
                        end else begin
                            burst_d = burst_q - BURST_W'(1);
                        end
                    end
`endif
                    default: begin
                        state_d = ARMED;
                        gap_d   = '0;
                    end
                endcase
            end
        end
    end

    // Registered channel outputs and the saturating flipped-bit counter.
    always_comb begin
        ch_d       = ch_q;
        ch_valid_d = enc_valid_i;
        err_inj_d  = '0;
        cnt_d      = cnt_q;
        if (enc_valid_i) begin
            ch_d      = enc_i ^ mask;
            err_inj_d = mask;
        end
        // Clear wins over a coincident flip; the flip still reaches ch_o.
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (enc_valid_i && (mask != 2'b00) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, gap counter, outputs and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARMED;
            gap_q      <= '0;
            ch_q       <= '0;
            ch_valid_q <= 1'b0;
            err_inj_q  <= '0;
            cnt_q      <= '0;
`ifdef VITERBI_CH_ERR_BURST_EN
            burst_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            ch_q       <= ch_d;
            ch_valid_q <= ch_valid_d;
            err_inj_q  <= err_inj_d;
            cnt_q      <= cnt_d;
`ifdef VITERBI_CH_ERR_BURST_EN
            burst_q    <= burst_d;
`endif
        end
    end

    assign ch_o         = ch_q;
    assign ch_valid_o   = ch_valid_q;
    assign err_inj_o    = err_inj_q;
    assign bad_bit_ct_o = cnt_q;

endmodule

// File: tb/tb_viterbi_channel_err_inj.sv
// Self-checking bench for viterbi_channel_err_inj. Two instances: A with
// MIN_GAP=4/CNT_W=16, B with MIN_GAP=0/CNT_W=4/SEED=0 (replaced by 16'hACE1).
module tb_viterbi_channel_err_inj;

    localparam int BURST_LEN = 3;

    logic       clk;
    logic       rst;
    logic       enc_valid;
    logic [1:0] enc;
    logic       err_en;
    logic [7:0] err_rate;
    logic       clr_cnt;

    logic [1:0]  a_ch, a_err, b_ch, b_err;
    logic        a_valid, b_valid;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int checks   = 0;
    int failures = 0;

    viterbi_channel_err_inj #(.MIN_GAP(4), .SEED(16'hACE1), .CNT_W(16), .BURST_LEN(BURST_LEN)) dut_a (
        .clk(clk), .rst(rst), .enc_valid_i(enc_valid), .enc_i(enc), .err_en_i(err_en),
        .err_rate_i(err_rate), .clr_cnt_i(clr_cnt), .ch_o(a_ch), .ch_valid_o(a_valid),
        .err_inj_o(a_err), .bad_bit_ct_o(a_cnt)
    );

    viterbi_channel_err_inj #(.MIN_GAP(0), .SEED(16'h0000), .CNT_W(4), .BURST_LEN(BURST_LEN)) dut_b (
        .clk(clk), .rst(rst), .enc_valid_i(enc_valid), .enc_i(enc), .err_en_i(err_en),
        .err_rate_i(err_rate), .clr_cnt_i(clr_cnt), .ch_o(b_ch), .ch_valid_o(b_valid),
        .err_inj_o(b_err), .bad_bit_ct_o(b_cnt)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int          sel;        // 0 = dut_a, 1 = dut_b
    logic [15:0] m_lfsr;
    int          m_clean;    // forced-clean symbols still owed
    int          m_burst;    // burst symbols still owed
    logic [1:0]  m_ch;
    int          m_cnt;
    logic        last_bs;

    function automatic int cur_gap();
        return (sel == 1) ? 0 : 4;
    endfunction

    function automatic int cnt_max();
        return (sel == 1) ? 15 : 65535;
    endfunction

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb = fb ^ s[taps[i] - 1];
        return {s[14:0], fb};
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_clean = 0;
        m_burst = 0;
        m_ch    = 2'b00;
        m_cnt   = 0;
    endtask

    task automatic model_mask(input logic en, input logic [7:0] rate,
                              output logic [1:0] mask, output logic bs);
        logic [15:0] l;
        logic [1:0]  pick;
        l      = m_lfsr;
        m_lfsr = ref_next(l);
        pick   = l[8] ? 2'b10 : 2'b01;
        mask   = 2'b00;
        bs     = 1'b0;
        if (!en) begin
            m_clean = 0;
            m_burst = 0;
        end else if (m_burst > 0) begin
            mask    = pick;
            m_burst = m_burst - 1;
            if (m_burst == 0) m_clean = cur_gap();
        end else if (m_clean > 0) begin
            m_clean = m_clean - 1;
        end else if (int'(l[7:0]) < int'(rate)) begin
            mask = pick;
`ifdef VITERBI_CH_ERR_BURST_EN
            if (l[15:12] == 4'hF) begin
                m_burst = BURST_LEN - 1;
                bs      = 1'b1;
            end else begin
                m_clean = cur_gap();
            end
`else
            m_clean = cur_gap();
`endif
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, called at a negedge; checks selected DUT against the model.
    task automatic cycle(input logic v, input logic [1:0] e, input logic en,
                         input logic [7:0] rate, input logic clr, output logic [1:0] got_err);
        logic [1:0] mask;
        logic       bs;
        enc_valid = v;
        enc       = e;
        err_en    = en;
        err_rate  = rate;
        clr_cnt   = clr;
        mask      = 2'b00;
        bs        = 1'b0;
        if (v) begin
            model_mask(en, rate, mask, bs);
            m_ch = e ^ mask;
        end
        if (clr) m_cnt = 0;
        else if (v && mask != 2'b00 && m_cnt < cnt_max()) m_cnt = m_cnt + 1;
        last_bs = bs;
        @(posedge clk);
        #1;
        if (sel == 1) begin
            check("ch_o",         32'(b_ch),    32'(m_ch));
            check("ch_valid_o",   32'(b_valid), 32'(v));
            check("err_inj_o",    32'(b_err),   32'(mask));
            check("bad_bit_ct_o", 32'(b_cnt),   32'(m_cnt));
            got_err = b_err;
        end else begin
            check("ch_o",         32'(a_ch),    32'(m_ch));
            check("ch_valid_o",   32'(a_valid), 32'(v));
            check("err_inj_o",    32'(a_err),   32'(mask));
            check("bad_bit_ct_o", 32'(a_cnt),   32'(m_cnt));
            got_err = a_err;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enc_valid = 1'b0;
        enc       = 2'b00;
        err_en    = 1'b0;
        err_rate  = 8'd0;
        clr_cnt   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic       v;
        logic [1:0] enc;
        logic       en;
        logic [7:0] rate;
        logic       exp_valid;
        logic [1:0] exp_ch;
        logic [1:0] exp_err;
    } tv_t;

    tv_t        tv [8];
    logic [1:0] stim [100];
    logic [1:0] gapfree [100];
    logic [1:0] e1 [$];
    logic [1:0] s1 [$];
    logic [7:0] r1 [$];

    initial begin
        logic [1:0] got;
        int         last_idx;
        int         k;
        bit         done;

        tv[0] = '{1'b1, 2'b01, 1'b1, 8'd0,   1'b1, 2'b01, 2'b00};
        tv[1] = '{1'b1, 2'b10, 1'b1, 8'd0,   1'b1, 2'b10, 2'b00};
        tv[2] = '{1'b0, 2'b11, 1'b1, 8'd0,   1'b0, 2'b10, 2'b00};
        tv[3] = '{1'b1, 2'b11, 1'b0, 8'd255, 1'b1, 2'b11, 2'b00};
        tv[4] = '{1'b1, 2'b00, 1'b0, 8'd255, 1'b1, 2'b00, 2'b00};
        tv[5] = '{1'b0, 2'b01, 1'b0, 8'd255, 1'b0, 2'b00, 2'b00};
        tv[6] = '{1'b1, 2'b10, 1'b1, 8'd0,   1'b1, 2'b10, 2'b00};
        tv[7] = '{1'b0, 2'b00, 1'b1, 8'd255, 1'b0, 2'b10, 2'b00};

        sel = 0;
        rst = 1'b1;
        enc_valid = 1'b0; enc = 2'b00; err_en = 1'b0; err_rate = 8'd0; clr_cnt = 1'b0;
        model_reset();
        @(negedge clk);
        // Reset values of both instances.
        check("rst_a_ch",    32'(a_ch),    32'h0);
        check("rst_a_valid", 32'(a_valid), 32'h0);
        check("rst_a_err",   32'(a_err),   32'h0);
        check("rst_a_cnt",   32'(a_cnt),   32'h0);
        check("rst_b_cnt",   32'(b_cnt),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: zero rate / disabled injection, idle hold behaviour.
        for (int i = 0; i < 8; i++) begin
            enc_valid = tv[i].v; enc = tv[i].enc; err_en = tv[i].en; err_rate = tv[i].rate;
            @(posedge clk);
            #1;
            check("tv_valid", 32'(a_valid), 32'(tv[i].exp_valid));
            check("tv_ch",    32'(a_ch),    32'(tv[i].exp_ch));
            check("tv_err",   32'(a_err),   32'(tv[i].exp_err));
            check("tv_cnt",   32'(a_cnt),   32'h0);
            @(negedge clk);
        end

        // Rate 0: 256 alternating symbols pass clean.
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 8'd0, 1'b0, got);
        check("rate0_cnt", 32'(a_cnt), 32'h0);

        // Rate 255, MIN_GAP=4, 100 back-to-back symbols.
        do_reset();
        last_idx = -100;
        for (int i = 0; i < 100; i++) begin
            stim[i] = 2'($urandom_range(0, 3));
            cycle(1'b1, stim[i], 1'b1, 8'd255, 1'b0, got);
            gapfree[i] = got;
            if (got != 2'b00) begin
                check("onehot", 32'($onehot(got)), 32'h1);
`ifndef VITERBI_CH_ERR_BURST_EN
                if (last_idx >= 0) check("spacing_ge5", 32'(i - last_idx >= 5), 32'h1);
`endif
                last_idx = i;
            end
        end
        check("rate255_cnt", 32'(a_cnt), 32'(m_cnt));

        // Same stream with idle gaps: pattern must match the gap-free run.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i == 20 || i == 50 || i == 75) begin
                for (int j = 0; j < 10; j++) cycle(1'b0, 2'($urandom_range(0, 3)), 1'b1, 8'd255, 1'b0, got);
            end
            cycle(1'b1, stim[i], 1'b1, 8'd255, 1'b0, got);
            check("gap_pattern", 32'(got), 32'(gapfree[i]));
        end

        // Instance B: saturation at 15, then clear on a flipped symbol.
        sel = 1;
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, 8'd255, 1'b0, got);
        check("sat_cnt", 32'(b_cnt), 32'd15);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            logic clr;
            logic [1:0] e;
            clr = (m_lfsr[7:0] != 8'hFF);
            e   = 2'($urandom_range(0, 3));
            cycle(1'b1, e, 1'b1, 8'd255, clr, got);
            if (clr && got != 2'b00) begin
                check("clr_cnt_zero", 32'(b_cnt), 32'h0);
                check("clr_flip_vis", 32'(b_ch),  32'(e ^ got));
                done = 1'b1;
            end
        end
        check("clr_found", 32'(done), 32'h1);
        cycle(1'b1, 2'b00, 1'b1, 8'd255, 1'b0, got);

        // Async reset while in HOLDOFF, then replay.
        sel = 0;
        do_reset();
        k = 0;
        done = 1'b0;
        while (k < 80 && !done) begin
            s1.push_back(2'($urandom_range(0, 3)));
            r1.push_back(8'($urandom_range(128, 255)));
            cycle(1'b1, s1[k], 1'b1, r1[k], 1'b0, got);
            e1.push_back(got);
            k = k + 1;
            if (k >= 10 && m_clean > 0 && m_burst == 0) done = 1'b1;
        end
        check("holdoff_reached", 32'(done), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_a_ch",    32'(a_ch),    32'h0);
        check("arst_a_valid", 32'(a_valid), 32'h0);
        check("arst_a_err",   32'(a_err),   32'h0);
        check("arst_a_cnt",   32'(a_cnt),   32'h0);
        check("arst_b_cnt",   32'(b_cnt),   32'h0);
        model_reset();
        enc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < k; i++) begin
            cycle(1'b1, s1[i], 1'b1, r1[i], 1'b0, got);
            check("replay_err", 32'(got), 32'(e1[i]));
        end

        // Random mixed stimulus against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 9,
                  8'($urandom), $urandom_range(0, 19) == 0, got);
        end

`ifdef VITERBI_CH_ERR_BURST_EN
        // Burst: 3 flipped symbols, then 4 clean; err_en drop aborts a burst.
        do_reset();
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, 8'd255, 1'b0, got);
            if (last_bs) done = 1'b1;
        end
        check("burst_found", 32'(done), 32'h1);
        if (done) begin
            check("burst_sym0", 32'(got != 2'b00), 32'h1);
            for (int j = 0; j < BURST_LEN - 1; j++) begin
                cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, 8'd255, 1'b0, got);
                check("burst_flip", 32'(got != 2'b00), 32'h1);
            end
            for (int j = 0; j < 4; j++) begin
                cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, 8'd255, 1'b0, got);
                check("burst_gap", 32'(got), 32'h0);
            end
            done = 1'b0;
            for (int i = 0; i < 2000 && !done; i++) begin
                cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, 8'd255, 1'b0, got);
                if (last_bs) done = 1'b1;
            end
            check("burst2_found", 32'(done), 32'h1);
            cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0, 8'd255, 1'b0, got);
            check("burst_abort", 32'(got), 32'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_channel_err_inj.md
# viterbi_channel_err_inj

Channel-model stage between the rate-1/2 convolutional encoder and the Viterbi decoder inside the tx/rx loop. Accepts one 2-bit encoded symbol per valid cycle and forwards it with pseudo-random single-bit flips driven by an internal LFSR. A minimum error spacing keeps faults within the decoder's correction capability. It reports a per-symbol error mask and a running corrupted-bit count for the bench scoreboard.

## Interface
- MIN_GAP, 4: accepted symbols forced clean after every injected error (0 = no holdoff).
- SEED, 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.
- CNT_W, 16: width of the corrupted-bit counter.
- BURST_LEN, 3: symbols per burst (only with ERR_BURST_EN).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enc_valid_i  in  1  enc_i holds a symbol this cycle.
- enc_i  in  2  encoded symbol {g1,g0} from the encoder.
- err_en_i  in  1  injection enable.
- err_rate_i  in  8  hit threshold; probability ≈ err_rate_i/256 per armed symbol.
- clr_cnt_i  in  1  synchronous clear of bad_bit_ct_o.
- ch_o  out  2  channel symbol to the decoder.
- ch_valid_o  out  1  ch_o valid.
- err_inj_o  out  2  flip mask applied to the current ch_o.
- bad_bit_ct_o  out  CNT_W  saturating count of flipped bits.

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps once per accepted symbol (enc_valid_i=1) and never otherwise.
- Decisions use the pre-step LFSR value L.
- hit = err_en_i & (L[7:0] < err_rate_i). err_rate_i=0 never hits; 255 hits 255/256.
- Flip mask on a hit: 2'b01 if L[8]=0, else 2'b10. Always one-hot.
- State machine: ARMED, HOLDOFF, BURST. It advances only on accepted symbols.
  - ARMED: no hit gives mask 0. A hit applies the mask, then goes to HOLDOFF with gap_cnt=MIN_GAP, or stays in ARMED if MIN_GAP=0.
  - HOLDOFF: mask 0; gap_cnt decrements. After MIN_GAP accepted symbols, returns to ARMED, so the next symbol is eligible.
  - BURST: see Configuration.
- err_en_i=0 on an accepted symbol: mask 0, state forced to ARMED, gap_cnt cleared. The LFSR still steps.
- Output: ch_o = enc_i ^ mask; err_inj_o = mask; ch_valid_o = enc_valid_i.
- Non-valid cycle: ch_valid_o=0, err_inj_o=0, and ch_o holds its last value.
- bad_bit_ct_o adds popcount(mask) (0 or 1) per accepted symbol and saturates at 2^CNT_W-1.
- clr_cnt_i has priority: the count becomes 0 and a coincident flip is not counted. The flip itself still appears on ch_o.

## Timing
- Latency is 1 cycle: a symbol accepted at edge N appears on ch_o, err_inj_o and ch_valid_o after edge N.
- Throughput is 1 symbol per cycle, with no backpressure.
- Reset values: ch_o=0, ch_valid_o=0, err_inj_o=0, bad_bit_ct_o=0. State is ARMED, gap_cnt=0, LFSR=SEED.
- Reset mid-operation clears outputs asynchronously. The post-reset error pattern is bit-identical to the pattern after the first reset for the same stimulus.
- Counter update and clear are visible on the same edge as the corresponding ch_o.

## Configuration
- Macro: VITERBI_CH_ERR_BURST_EN.
- Defined:
  - A hit in ARMED with L[15:12]=4'hF enters BURST.
  - That symbol and the next BURST_LEN-1 accepted symbols each get a flip, with the bit chosen per symbol by that symbol's L[8].
  - After the burst, the block enters HOLDOFF (MIN_GAP).
  - err_en_i=0 aborts the burst and returns the block to ARMED.
- Not defined: the BURST state and BURST_LEN logic are absent, and every hit is a single flip.

## Structure
- Shared package viterbi_pkg holds:
  - sym_t (logic [1:0]).
  - ch_state_t enum {ARMED, HOLDOFF, BURST}.
  - LFSR tap mask constant and default seed 16'hACE1.
- Sub-module viterbi_lfsr16 (ports: clk, rst, step, seed, state) is shared with any future stimulus generators.
- Counter and FSM live in the top module.

## Test plan
- err_rate_i=0, err_en_i=1, 256 symbols alternating 01/10 -> ch_o equals enc_i one cycle later, err_inj_o=0 throughout, bad_bit_ct_o=0.
- err_rate_i=255, MIN_GAP=4, 100 back-to-back symbols:
  - Every nonzero err_inj_o is one-hot.
  - Nonzero masks are at least 5 symbols apart.
  - bad_bit_ct_o equals the reference-model count.
- Valid gaps of 10 idle cycles inside the last run -> ch_valid_o=0 and err_inj_o=0 while idle. The LFSR is frozen, so the resumed error pattern equals the gap-free run.
- CNT_W=4, MIN_GAP=0, err_rate_i=255, 40 symbols -> bad_bit_ct_o saturates at 15. clr_cnt_i on a flipped symbol -> 0 next cycle, that flip still visible on ch_o.
- Async rst pulse while in HOLDOFF -> all outputs 0 immediately. Replaying the same stimulus reproduces the first run's err_inj_o sequence exactly.
- With VITERBI_CH_ERR_BURST_EN, BURST_LEN=3, MIN_GAP=4, err_rate_i=255 -> on the first burst trigger, exactly 3 consecutive flipped symbols, then 4 clean ones. err_en_i dropped mid-burst -> next mask 0.
